imem_responder: RTL and testbench

//  Responder end of the fetch-stage memory handshake (mem_request/mem_resp).

---
 rtl/imem_responder.sv | 148 ++++++++++++++
 tb/tb_imem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Fetch-side responder: serves 16-bit instruction reads out of one buffered line and
// refills that line from physical memory with a single burst on a miss.
module imem_responder #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_request,
  input  logic [ADDR_W-1:0]        mem_address,
  input  logic                     flush,
  output logic [15:0]              mem_rdata,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic [ADDR_W-1:0]        pmem_address,
  input  logic [LINE_WORDS*16-1:0] pmem_rdata,
  input  logic                     pmem_resp,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = ADDR_W - OffW - 1;

  typedef enum logic [1:0] {StIdle, StFill, StRespond} state_e;

  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic [TagW-1:0]         tag_q, tag_d;
  logic [LINE_WORDS*16-1:0] line_q, line_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
  logic [15:0]             mem_rdata_q, mem_rdata_d;
  logic                    mem_resp_q, mem_resp_d;
  logic                    pmem_read_q, pmem_read_d;
  logic [ADDR_W-1:0]       pmem_address_q, pmem_address_d;
  logic [15:0]             hit_q, hit_d;
  logic [15:0]             miss_q, miss_d;

  logic [TagW-1:0] cur_tag;
  logic [OffW-1:0] cur_off;
  logic [OffW-1:0] req_off;

  assign cur_tag = mem_address[ADDR_W-1:OffW+1];
  assign cur_off = mem_address[OffW:1];
  assign req_off = req_addr_q[OffW:1];

  function automatic logic [15:0] pick(input logic [LINE_WORDS*16-1:0] l,
                                       input logic [OffW-1:0] o);
    pick = l[o*16 +: 16];
  endfunction

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    flush_pend_d   = flush_pend_q;
    req_addr_d     = req_addr_q;
    mem_rdata_d    = mem_rdata_q;
    mem_resp_d     = 1'b0;
    pmem_read_d    = pmem_read_q;
    pmem_address_d = pmem_address_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    case (state_q)
      StIdle: begin
        // A flush takes priority; a concurrent request is looked up again next cycle.
        if (flush) begin
          valid_d = 1'b0;
        end else if (mem_request && valid_q && (cur_tag == tag_q)) begin
          state_d     = StRespond;
          mem_resp_d  = 1'b1;
          mem_rdata_d = pick(line_q, cur_off);
          if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
        end else if (mem_request) begin
          state_d        = StFill;
          req_addr_d     = mem_address;
          pmem_read_d    = 1'b1;
          pmem_address_d = {cur_tag, {(OffW+1){1'b0}}};
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
        end
      end
      StFill: begin
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          line_d       = pmem_rdata;
          tag_d        = req_addr_q[ADDR_W-1:OffW+1];
          valid_d      = ~(flush | flush_pend_q);
          flush_pend_d = 1'b0;
          // The fresh word is returned even if the line was flushed during the fill.
          if (mem_request && (mem_address == req_addr_q)) begin
            state_d     = StRespond;
            mem_resp_d  = 1'b1;
            mem_rdata_d = pick(pmem_rdata, req_off);
          end else begin
            state_d = StIdle;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      StRespond: begin
        state_d = StIdle;
        if (flush) valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      valid_q        <= 1'b0;
      tag_q          <= '0;
      line_q         <= '0;
      flush_pend_q   <= 1'b0;
      req_addr_q     <= '0;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= '0;
      hit_q          <= '0;
      miss_q         <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      flush_pend_q   <= flush_pend_d;
      req_addr_q     <= req_addr_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_read_q    <= pmem_read_d;
      pmem_address_q <= pmem_address_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
    end
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = pmem_address_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: miss/hit latency, flush during fill, withdrawn
// requests, asynchronous reset mid-fill and hit counter saturation.
module tb_imem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_request;
  logic [15:0]  mem_address;
  logic         flush;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  imem_responder #(.LINE_WORDS(8), .ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_request  (mem_request),
    .mem_address  (mem_address),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Present a line whose word i is base+i, with pmem_resp for one cycle.
  task automatic set_line(input logic [15:0] base);
    for (int i = 0; i < 8; i++) pmem_rdata[i*16 +: 16] = base + 16'(i);
    pmem_resp = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mem_request = 1'b0; mem_address = '0; flush = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    #1;
    chk("reset_resp", {31'd0, mem_resp}, 32'd0);
    chk("reset_pread", {31'd0, pmem_read}, 32'd0);
    chk("reset_paddr", {16'd0, pmem_address}, 32'd0);
    chk("reset_rdata", {16'd0, mem_rdata}, 32'd0);
    chk("reset_hits", {16'd0, hit_count}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // T1 cold miss
    mem_request = 1'b1; mem_address = 16'h3004;
    tick();
    chk("t1_pread", {31'd0, pmem_read}, 32'd1);
    chk("t1_paddr", {16'd0, pmem_address}, 32'h3000);
    chk("t1_miss", {16'd0, miss_count}, 32'd1);
    chk("t1_noresp", {31'd0, mem_resp}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("t1_pread_held", {31'd0, pmem_read}, 32'd1);
    set_line(16'hA000);
    tick();
    pmem_resp = 1'b0; mem_request = 1'b0;
    chk("t1_resp", {31'd0, mem_resp}, 32'd1);
    chk("t1_rdata", {16'd0, mem_rdata}, 32'hA002);
    chk("t1_pread_drop", {31'd0, pmem_read}, 32'd0);
    tick();
    chk("t1_resp_pulse", {31'd0, mem_resp}, 32'd0);
    chk("t1_rdata_hold", {16'd0, mem_rdata}, 32'hA002);

    // T2 hit
    mem_request = 1'b1; mem_address = 16'h300E;
    tick();
    mem_request = 1'b0;
    chk("t2_resp", {31'd0, mem_resp}, 32'd1);
    chk("t2_rdata", {16'd0, mem_rdata}, 32'hA007);
    chk("t2_hits", {16'd0, hit_count}, 32'd1);
    chk("t2_pread", {31'd0, pmem_read}, 32'd0);
    tick();

    // T3 flush during fill
    mem_request = 1'b1; mem_address = 16'h4000;
    tick();
    chk("t3_paddr", {16'd0, pmem_address}, 32'h4000);
    chk("t3_miss", {16'd0, miss_count}, 32'd2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    set_line(16'hB000);
    tick();
    pmem_resp = 1'b0; mem_request = 1'b0;
    chk("t3_resp", {31'd0, mem_resp}, 32'd1);
    chk("t3_rdata", {16'd0, mem_rdata}, 32'hB000);
    tick();
    mem_request = 1'b1; mem_address = 16'h4000;
    tick();
    chk("t3_remiss_pread", {31'd0, pmem_read}, 32'd1);
    chk("t3_remiss_count", {16'd0, miss_count}, 32'd3);
    chk("t3_remiss_hits", {16'd0, hit_count}, 32'd1);
    set_line(16'hC000);
    tick();
    pmem_resp = 1'b0; mem_request = 1'b0;
    chk("t3_refill_rdata", {16'd0, mem_rdata}, 32'hC000);
    tick();

    // T4 withdrawn request
    mem_request = 1'b1; mem_address = 16'h5006;
    tick();
    chk("t4_miss", {16'd0, miss_count}, 32'd4);
    mem_request = 1'b0;
    tick();
    set_line(16'hD000);
    tick();
    pmem_resp = 1'b0;
    chk("t4_noresp", {31'd0, mem_resp}, 32'd0);
    chk("t4_pread_drop", {31'd0, pmem_read}, 32'd0);
    tick();
    chk("t4_noresp_later", {31'd0, mem_resp}, 32'd0);
    mem_request = 1'b1; mem_address = 16'h5006;
    tick();
    mem_request = 1'b0;
    chk("t4_hit_resp", {31'd0, mem_resp}, 32'd1);
    chk("t4_hit_rdata", {16'd0, mem_rdata}, 32'hD003);
    chk("t4_hits", {16'd0, hit_count}, 32'd2);
    chk("t4_miss_same", {16'd0, miss_count}, 32'd4);
    tick();

    // T5 reset mid-fill
    mem_request = 1'b1; mem_address = 16'h6000;
    tick();
    chk("t5_pread", {31'd0, pmem_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_pread", {31'd0, pmem_read}, 32'd0);
    chk("t5_hits0", {16'd0, hit_count}, 32'd0);
    chk("t5_miss0", {16'd0, miss_count}, 32'd0);
    chk("t5_paddr0", {16'd0, pmem_address}, 32'd0);
    mem_request = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    set_line(16'hEEEE);
    tick();
    pmem_resp = 1'b0;
    chk("t5_stray_resp", {31'd0, mem_resp}, 32'd0);
    chk("t5_stray_pread", {31'd0, pmem_read}, 32'd0);
    tick();
    chk("t5_stray_resp2", {31'd0, mem_resp}, 32'd0);

    // T6 hit saturation: install a line, preload the counter near the top
    mem_request = 1'b1; mem_address = 16'h7000;
    tick();
    chk("t6_miss", {16'd0, miss_count}, 32'd1);
    set_line(16'hE000);
    tick();
    pmem_resp = 1'b0; mem_request = 1'b0;
    chk("t6_fill_rdata", {16'd0, mem_rdata}, 32'hE000);
    tick();
    force dut.hit_q = 16'hFFFD;
    tick();
    release dut.hit_q;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] exp_hits;
      exp_hits = (k == 0) ? 16'hFFFE : 16'hFFFF;
      mem_request = 1'b1; mem_address = 16'h7000 + 16'(2 * (k + 1));
      tick();
      mem_request = 1'b0;
      chk("t6_resp", {31'd0, mem_resp}, 32'd1);
      chk("t6_rdata", {16'd0, mem_rdata}, {16'd0, 16'hE000 + 16'(k + 1)});
      chk("t6_sat", {16'd0, hit_count}, {16'd0, exp_hits});
      tick();
    end

    // Flush in IDLE wins over a same-cycle request, which then misses
    mem_request = 1'b1; mem_address = 16'h7000; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_noresp", {31'd0, mem_resp}, 32'd0);
    chk("idle_flush_nopread", {31'd0, pmem_read}, 32'd0);
    tick();
    chk("idle_flush_miss_pread", {31'd0, pmem_read}, 32'd1);
    chk("idle_flush_miss_count", {16'd0, miss_count}, 32'd2);
    chk("idle_flush_hits_sat", {16'd0, hit_count}, 32'hFFFF);
    set_line(16'hF000);
    tick();
    pmem_resp = 1'b0; mem_request = 1'b0;
    chk("idle_flush_rdata", {16'd0, mem_rdata}, 32'hF000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
